wb_spi_multi: RTL and testbench
===============================

# wb_spi_multi

Wishbone-slave SPI master with a programmable clock divider, all four CPOL/CPHA modes, MSB/LSB-first ordering, a parametrised word width and multiple active-low chip selects. It sits on the SoC Wishbone bus next to the other `wb_*` peripherals. Software loads a word to start a full-duplex transfer, then polls `busy`/`done` or takes an interrupt, and reads back the received word.

## Interface
- `DATA_W`, 8: transfer word width, 4..32.
- `NUM_CS`, 4: number of chip-select outputs, 1..8.
- `DIV_W`, 8: divider register width.
- `DIV_RESET`, 7: divider value after reset.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  reset, synchronous, active-low (0 = reset).
- `wb_stb_i`, `wb_cyc_i`, `wb_we_i`  in  1  Wishbone strobe, cycle and write enable.
- `wb_adr_i`  in  32  byte address; only `[4:2]` is decoded.
- `wb_sel_i`  in  4  ignored; all accesses are full-word.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data; unused bits read 0.
- `wb_ack_o`  out  1  equals `wb_stb_i & wb_cyc_i & ack_q`.
- `spi_sck`  out  1  serial clock; idles at CPOL.
- `spi_mosi`  out  1  serial data out.
- `spi_miso`  in  1  serial data in.
- `spi_cs_n`  out  NUM_CS  active-low chip selects.
- `irq`  out  1  level interrupt; present only with `WB_SPI_MULTI_IRQ_EN`.

## Operation
- Registers, indexed by `wb_adr_i[4:2]`:
  - 0 CTRL/STATUS: `[0]` busy (RO), `[1]` done (sticky, write-1-clear), `[2]` overrun (sticky, W1C), `[3]` cpol, `[4]` cpha, `[5]` lsb_first, `[6]` ie.
  - 1 DATA: a write loads TX and starts a transfer. A read returns the last RX word in `[DATA_W-1:0]`.
  - 2 CS: `[2:0]` selects the target chip select. An index of NUM_CS or more asserts no CS, but the transfer still runs.
  - 3 DIV: `[DIV_W-1:0]`; SCK half-period is DIV+1 clk cycles.
  - Others read 0; writes to them are ignored.
- FSM states IDLE, LEAD, SHIFT, TRAIL. Each state change happens on a half-period tick from the divider counter.
  - IDLE → LEAD on a DATA write while idle: load the shift register, assert the selected `spi_cs_n`, set busy.
  - LEAD → SHIFT after one half-period (CS setup).
  - SHIFT covers 2·DATA_W half-periods. `spi_sck` toggles at each half-period tick.
  - SHIFT → TRAIL after the last edge. TRAIL → IDLE after one half-period (CS hold): deassert CS, clear busy, set done, latch RX.
- CPHA=0: first MOSI bit is driven in LEAD. MISO is sampled on the leading SCK edge; MOSI shifts on the trailing edge.
- CPHA=1: MOSI shifts on the leading edge; MISO is sampled on the trailing edge.
- lsb_first=1 shifts from bit 0; otherwise from bit DATA_W-1.
- A DATA write while busy is dropped and sets overrun; the transfer in progress is unaffected.
- Writes to cpol, cpha, lsb_first, CS or DIV while busy are ignored. W1C of done/overrun and writes to ie are always accepted.
- Boundaries:
  - DIV=0 gives SCK = clk/2.
  - A done W1C in the same cycle as transfer completion leaves done=1.
  - The RX register holds its old value until TRAIL completes.

## Timing
- Reset values: `wb_dat_o`=0, `ack_q`=0, `spi_sck`=0, `spi_mosi`=0, `spi_cs_n`=all 1, `irq`=0. CTRL=0, CS=0, DIV=DIV_RESET, TX/RX=0, FSM=IDLE.
- Bus: `ack_q` rises the cycle after a strobed request with `ack_q`=0, and lasts one cycle. Read data is registered and valid while ack is high. Each access takes 2 cycles minimum; there are no back-to-back acks.
- A DATA write takes effect on the same edge that sets `ack_q`. busy=1 and CS are low during the ack cycle.
- Transfer latency, from that edge to busy=0: (2·DATA_W+2)·(DIV+1) clk cycles. done reads 1 from the first poll after busy falls.
- Reset mid-transfer: all outputs return to reset values on the next edge, and no done is set.

## Configuration
- `WB_SPI_MULTI_IRQ_EN` defined:
  - the `irq` port exists, driven as `irq = ie & done`, registered;
  - CTRL bit 6 is writable.
- Not defined:
  - no `irq` port;
  - CTRL bit 6 reads 0 and ignores writes;
  - all other behaviour is identical.

## Structure
- Package `wb_spi_multi_pkg`:
  - register index constants;
  - CTRL bit position constants;
  - FSM state enum (IDLE, LEAD, SHIFT, TRAIL).
- Sub-module `spi_shift_engine` contains the FSM, divider counter, SCK generation, shift/sample logic and edge counter. It is parametrised by DATA_W and DIV_W.
- The top level keeps the Wishbone decode, register file, CS decode and irq.

## Test plan
- Reset with `reset`=0 for 3 cycles → every register reads its reset value, `spi_cs_n`=4'b1111, `spi_sck`=0.
- Mode 0, DIV=1, CS=2, `spi_mosi` looped to `spi_miso`, write DATA=0xA5 → `spi_cs_n`=4'b1011 during the transfer, MOSI shows 1,0,1,0,0,1,0,1, busy lasts 36 cycles, RX=0xA5, done=1.
- Mode 3, lsb_first=1, DIV=0, MISO driven from a model returning 0x3C → SCK idles high, MOSI is LSB-first, RX=0x3C after 18 cycles.
- Write DATA=0x11 and then DATA=0x22 while busy → only 0x11 is shifted, overrun=1, writing CTRL=0x4 clears overrun.
- Write DIV=3 while busy → the transfer keeps the old half-period, and DIV reads its old value afterwards.
- With `WB_SPI_MULTI_IRQ_EN`, ie=1, complete a transfer → `irq`=1; W1C done → `irq`=0 the next cycle.

Source files
------------

// File: rtl/wb_spi_multi_pkg.sv
// Shared definitions for wb_spi_multi: register indices, CTRL bit positions and the
// shift-engine state type.
package wb_spi_multi_pkg;

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_DATA = 3'd1;
  localparam logic [2:0] REG_CS   = 3'd2;
  localparam logic [2:0] REG_DIV  = 3'd3;

  localparam int unsigned CTRL_BUSY = 0;
  localparam int unsigned CTRL_DONE = 1;
  localparam int unsigned CTRL_OVR  = 2;
  localparam int unsigned CTRL_CPOL = 3;
  localparam int unsigned CTRL_CPHA = 4;
  localparam int unsigned CTRL_LSB  = 5;
  localparam int unsigned CTRL_IE   = 6;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL
  } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI transfer sequencer: half-period divider, SCK generation, MOSI shifting, MISO sampling
// and the edge counter that walks a DATA_W-bit full-duplex transfer.
module spi_shift_engine
  import wb_spi_multi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  div,
  input  logic              miso,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  output logic              done,
  output logic [DATA_W-1:0] rx_word
);

  localparam int unsigned       IDX_W     = $clog2(DATA_W);
  localparam int unsigned       EDGE_W    = IDX_W + 1;
  localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_W - 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q;
  logic [EDGE_W-1:0] sck_edge_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic              tick;
  logic              lead_edge;
  logic [IDX_W-1:0]  bit_i;
  logic [IDX_W-1:0]  cur_pos;
  logic [IDX_W-1:0]  nxt_pos;

  // Maps the n-th transmitted bit to its position in the data word.
  function automatic logic [IDX_W-1:0] wire_pos(input logic lsb, input logic [IDX_W-1:0] i);
    return lsb ? i : LAST_BIT - i;
  endfunction

  always_comb begin
    tick      = (cnt_q == div);
    bit_i     = sck_edge_q[EDGE_W-1:1];
    lead_edge = ~sck_edge_q[0];
    cur_pos   = wire_pos(lsb_first, bit_i);
    nxt_pos   = wire_pos(lsb_first, bit_i + 1'b1);
    state_d   = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LEAD;
      LEAD:    if (tick) state_d = SHIFT;
      SHIFT:   if (tick && sck_edge_q == LAST_EDGE) state_d = TRAIL;
      TRAIL:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == TRAIL) && tick;
  assign rx_word = rx_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q      <= '0;
      sck_edge_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      sck        <= 1'b0;
      mosi       <= 1'b0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
      sck   <= cpol;
      if (start) begin
        tx_q       <= tx_data;
        sck_edge_q <= '0;
        mosi       <= tx_data[wire_pos(lsb_first, '0)];
      end
    end else if (!tick) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
      if (state_q == SHIFT) begin
        sck        <= ~sck;
        sck_edge_q <= sck_edge_q + 1'b1;
        // Sample on leading edge when cpha=0, trailing when cpha=1; shift on the other one.
        if (lead_edge ^ cpha)     rx_q[cur_pos] <= miso;
        else if (cpha)            mosi <= tx_q[cur_pos];
        else if (bit_i != LAST_BIT) mosi <= tx_q[nxt_pos];
      end
    end
  end

endmodule

// File: rtl/wb_spi_multi.sv
// Wishbone-slave SPI master: bus decode, register file, chip-select decode and optional
// level interrupt (enabled by defining WB_SPI_MULTI_IRQ_EN).
module wb_spi_multi
  import wb_spi_multi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_CS    = 4,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned DIV_RESET = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
`ifdef WB_SPI_MULTI_IRQ_EN
  ,
  output logic              irq
`endif
);

  logic              ack_q;
  logic              req, rd;
  logic              wr_ctrl, wr_data, wr_cs, wr_div;
  logic              start, busy, eng_done;
  logic [2:0]        reg_idx;
  logic              done_q, overrun_q, cpol_q, cpha_q, lsb_q, ie_q;
  logic [2:0]        cs_sel_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] rx_q, eng_rx;
  logic [31:0]       rd_mux;
  logic              unused_bits;

  assign reg_idx     = wb_adr_i[4:2];
  assign req         = wb_stb_i & wb_cyc_i & ~ack_q;
  assign rd          = req & ~wb_we_i;
  assign wb_ack_o    = wb_stb_i & wb_cyc_i & ack_q;
  assign start       = wr_data & ~busy;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

  always_comb begin
    wr_ctrl = req & wb_we_i & (reg_idx == REG_CTRL);
    wr_data = req & wb_we_i & (reg_idx == REG_DATA);
    wr_cs   = req & wb_we_i & (reg_idx == REG_CS);
    wr_div  = req & wb_we_i & (reg_idx == REG_DIV);
  end

  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      REG_CTRL: begin
        rd_mux[CTRL_BUSY] = busy;
        rd_mux[CTRL_DONE] = done_q;
        rd_mux[CTRL_OVR]  = overrun_q;
        rd_mux[CTRL_CPOL] = cpol_q;
        rd_mux[CTRL_CPHA] = cpha_q;
        rd_mux[CTRL_LSB]  = lsb_q;
        rd_mux[CTRL_IE]   = ie_q;
      end
      REG_DATA: rd_mux[DATA_W-1:0] = rx_q;
      REG_CS:   rd_mux[2:0]        = cs_sel_q;
      REG_DIV:  rd_mux[DIV_W-1:0]  = div_q;
      default:  rd_mux = '0;
    endcase
  end

  // An out-of-range index matches no output, so the transfer runs with every CS high.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CS; i++)
      spi_cs_n[i] = ~(busy && (cs_sel_q == 3'(i)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_q     <= 1'b0;
      wb_dat_o  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      cs_sel_q  <= '0;
      div_q     <= DIV_W'(DIV_RESET);
      rx_q      <= '0;
    end else begin
      ack_q     <= req;
      wb_dat_o  <= rd ? rd_mux : '0;
      // Completion wins over a simultaneous W1C of done.
      done_q    <= eng_done | (done_q & ~(wr_ctrl & wb_dat_i[CTRL_DONE]));
      overrun_q <= (wr_data & busy) | (overrun_q & ~(wr_ctrl & wb_dat_i[CTRL_OVR]));
      if (wr_ctrl && !busy) begin
        cpol_q <= wb_dat_i[CTRL_CPOL];
        cpha_q <= wb_dat_i[CTRL_CPHA];
        lsb_q  <= wb_dat_i[CTRL_LSB];
      end
      if (wr_cs && !busy)  cs_sel_q <= wb_dat_i[2:0];
      if (wr_div && !busy) div_q    <= wb_dat_i[DIV_W-1:0];
      if (eng_done)        rx_q     <= eng_rx;
    end
  end

`ifdef WB_SPI_MULTI_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      ie_q <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (wr_ctrl) ie_q <= wb_dat_i[CTRL_IE];
      irq <= ie_q & done_q;
    end
  end
`else
  assign ie_q = 1'b0;
`endif

  spi_shift_engine #(
    .DATA_W(DATA_W),
    .DIV_W (DIV_W)
  ) u_engine (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tx_data  (wb_dat_i[DATA_W-1:0]),
    .cpol     (cpol_q),
    .cpha     (cpha_q),
    .lsb_first(lsb_q),
    .div      (div_q),
    .miso     (spi_miso),
    .busy     (busy),
    .sck      (spi_sck),
    .mosi     (spi_mosi),
    .done     (eng_done),
    .rx_word  (eng_rx)
  );

endmodule

// File: tb/tb_wb_spi_multi.sv
// Self-checking bench for wb_spi_multi: bus-level scenarios plus randomized transfers checked
// against a bit-order / latency reference model (irq scenario when WB_SPI_MULTI_IRQ_EN is set).
`timescale 1ns/1ps
module tb_wb_spi_multi;

  localparam int unsigned W   = 8;
  localparam int unsigned NCS = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0]    wb_adr_i = '0;
  logic [3:0]     wb_sel_i = 4'hF;
  logic [31:0]    wb_dat_i = '0;
  logic [31:0]    wb_dat_o;
  logic           wb_ack_o;
  logic           spi_sck, spi_mosi, spi_miso;
  logic [NCS-1:0] spi_cs_n;
`ifdef WB_SPI_MULTI_IRQ_EN
  logic           irq;
`endif

  logic           loopback = 1'b1;
  logic           slave_bit = 1'b0;
  int unsigned    cyc_cnt = 0;
  int unsigned    ack_cyc = 0;
  int             passed = 0;
  int             total = 0;
  logic [W-1:0]   last_rx = '0;

  assign spi_miso = loopback ? spi_mosi : slave_bit;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_spi_multi #(
    .DATA_W   (W),
    .NUM_CS   (NCS),
    .DIV_W    (8),
    .DIV_RESET(7)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
`ifdef WB_SPI_MULTI_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  function automatic int unsigned order(input logic lsb, input int unsigned k);
    return lsb ? k : W - 1 - k;
  endfunction

  task automatic wb_access(input logic we, input logic [2:0] idx, input logic [31:0] d,
                           output logic [31:0] q);
    logic ok;
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
    wb_adr_i = {27'd0, idx, 2'b00}; wb_dat_i = d;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o === 1'b1) begin ok = 1'b1; break; end
    end
    ack_cyc = cyc_cnt;
    q = wb_dat_o;
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL bus_ack_timeout: reg %0d got no ack, required ack within 8 cycles", idx);
    end
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] d);
    logic [31:0] q;
    wb_access(1'b1, idx, d, q);
  endtask

  task automatic wb_read(input logic [2:0] idx, output logic [31:0] q);
    wb_access(1'b0, idx, '0, q);
  endtask

  task automatic wait_idle(input int unsigned limit);
    logic [31:0] s;
    for (int unsigned i = 0; i < limit; i++) begin
      wb_read(3'd0, s);
      if (s[0] === 1'b0) return;
    end
    total++;
    $display("FAIL busy_timeout: busy still 1 after %0d polls, required 0", limit);
  endtask

  // Reference transfer: configure, start, then watch the pins cycle by cycle.
  task automatic run_transfer(input logic [W-1:0] tx, input logic [W-1:0] sword, input logic lb,
                              input logic cpol, input logic cpha, input logic lsb,
                              input int unsigned div, input int unsigned cs);
    int unsigned    lat, t0, nedges, nbits, cs_bad;
    logic [NCS-1:0] exp_cs, want_cs, cs_first_bad;
    logic [W-1:0]   mosi_word, exp_rx;
    logic           prev_sck;
    logic [31:0]    d;
    lat    = (2 * W + 2) * (div + 1);
    exp_cs = '1;
    if (cs < NCS) exp_cs[cs] = 1'b0;
    exp_rx = lb ? tx : sword;
    wb_write(3'd0, 32'h6 | (32'(cpol) << 3) | (32'(cpha) << 4) | (32'(lsb) << 5));
    wb_write(3'd2, 32'(cs));
    wb_write(3'd3, 32'(div));
    total++;
    if (spi_sck !== cpol) $display("FAIL sck_idle: got %b, required %b", spi_sck, cpol);
    else passed++;
    loopback  = lb;
    slave_bit = sword[order(lsb, 0)];
    wb_write(3'd1, 32'(tx));
    t0 = ack_cyc;
    prev_sck = cpol; nedges = 0; nbits = 0; cs_bad = 0;
    mosi_word = '0; cs_first_bad = '0;
    for (int unsigned k = 0; k < lat + 3; k++) begin
      want_cs = (k < lat) ? exp_cs : '1;
      if (spi_cs_n !== want_cs) begin
        cs_bad++;
        if (cs_bad == 1) cs_first_bad = spi_cs_n;
      end
      @(posedge clk); #1;
      if (spi_sck !== prev_sck) begin
        nedges++;
        if ((prev_sck === cpol) != cpha) begin
          if (nbits < W) mosi_word[order(lsb, nbits)] = spi_mosi;
          nbits++;
          if (nbits < W) slave_bit = sword[order(lsb, nbits)];
        end
        prev_sck = spi_sck;
      end
    end
    total++;
    if (cs_bad != 0)
      $display("FAIL cs_timing: %0d bad cycles (first cs_n=%b), required 0 (cs_n=%b for %0d cycles)",
               cs_bad, cs_first_bad, exp_cs, lat);
    else passed++;
    total++;
    if (nedges != 2 * W) $display("FAIL sck_edges: got %0d, required %0d", nedges, 2 * W);
    else passed++;
    total++;
    if (spi_sck !== cpol) $display("FAIL sck_end: got %b, required %b", spi_sck, cpol);
    else passed++;
    total++;
    if (mosi_word !== tx) $display("FAIL mosi_bits: got %h, required %h", mosi_word, tx);
    else passed++;
    wb_read(3'd1, d);
    total++;
    if (d !== 32'(exp_rx)) $display("FAIL rx_data: got %h, required %h", d, exp_rx);
    else passed++;
    wb_read(3'd0, d);
    total++;
    if (d[2:0] !== 3'b010) $display("FAIL status_after: got %b, required 010", d[2:0]);
    else passed++;
    last_rx = exp_rx;
  endtask

  task automatic test_reset;
    logic [31:0] d, e;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({spi_cs_n, spi_sck, spi_mosi, wb_ack_o} !== {{NCS{1'b1}}, 3'b000})
      $display("FAIL reset_pins: got cs_n=%b sck=%b mosi=%b ack=%b, required 1111 0 0 0",
               spi_cs_n, spi_sck, spi_mosi, wb_ack_o);
    else passed++;
    total++;
    if (wb_dat_o !== 32'd0) $display("FAIL reset_dat_o: got %h, required 0", wb_dat_o);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      e = (i == 3) ? 32'd7 : 32'd0;
      wb_read(3'(i), d);
      total++;
      if (d !== e) $display("FAIL reset_reg%0d: got %h, required %h", i, d, e);
      else passed++;
    end
    wb_write(3'd5, 32'hFFFF_FFFF);
    wb_read(3'd5, d);
    total++;
    if (d !== 32'd0) $display("FAIL unmapped_reg: got %h, required 0", d);
    else passed++;
  endtask

  task automatic test_mode0_loopback;
    run_transfer(8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 2);
  endtask

  task automatic test_mode3_lsb;
    run_transfer(W'($urandom), 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++)
      run_transfer(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 5));
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    loopback = 1'b1;
    wb_write(3'd0, 32'h6);
    wb_write(3'd2, 32'd0);
    wb_write(3'd3, 32'd7);
    wb_write(3'd1, 32'h11);
    wb_write(3'd1, 32'h22);
    wb_read(3'd1, d);
    total++;
    if (d !== 32'(last_rx)) $display("FAIL rx_hold: got %h, required %h", d, last_rx);
    else passed++;
    wb_read(3'd0, d);
    total++;
    if (d[2:0] !== 3'b101) $display("FAIL overrun_set: got %b, required 101", d[2:0]);
    else passed++;
    wait_idle(100);
    wb_read(3'd1, d);
    total++;
    if (d !== 32'h11) $display("FAIL overrun_rx: got %h, required 11", d);
    else passed++;
    wb_write(3'd0, 32'h4);
    wb_read(3'd0, d);
    total++;
    if (d[2:0] !== 3'b010) $display("FAIL overrun_clear: got %b, required 010", d[2:0]);
    else passed++;
    last_rx = 8'h11;
  endtask

  task automatic test_div_busy;
    logic [31:0] d;
    logic [W-1:0] tx;
    int unsigned t0;
    loopback = 1'b1;
    tx = W'($urandom);
    wb_write(3'd0, 32'h6);
    wb_write(3'd2, 32'd1);
    wb_write(3'd3, 32'd1);
    wb_write(3'd1, 32'(tx));
    t0 = ack_cyc;
    wb_write(3'd3, 32'd3);
    while (spi_cs_n !== 4'b1111 && cyc_cnt < t0 + 200) begin
      @(posedge clk); #1;
    end
    total++;
    if (cyc_cnt - t0 != 36) $display("FAIL div_busy_latency: got %0d, required 36", cyc_cnt - t0);
    else passed++;
    wb_read(3'd3, d);
    total++;
    if (d !== 32'd1) $display("FAIL div_busy_value: got %h, required 1", d);
    else passed++;
    wb_read(3'd1, d);
    total++;
    if (d !== 32'(tx)) $display("FAIL div_busy_rx: got %h, required %h", d, tx);
    else passed++;
    last_rx = tx;
  endtask

  task automatic test_done_race;
    logic [31:0] d;
    logic [W-1:0] tx;
    int unsigned t0, lat;
    loopback = 1'b1;
    tx  = W'($urandom);
    lat = (2 * W + 2) * 3;
    wb_write(3'd0, 32'h6);
    wb_write(3'd2, 32'd1);
    wb_write(3'd3, 32'd2);
    wb_write(3'd1, 32'(tx));
    t0 = ack_cyc;
    while (cyc_cnt < t0 + lat - 1) begin
      @(posedge clk); #1;
    end
    wb_write(3'd0, 32'h2);
    total++;
    if (ack_cyc != t0 + lat) $display("FAIL race_align: got cycle %0d, required %0d", ack_cyc - t0, lat);
    else passed++;
    wb_read(3'd0, d);
    total++;
    if (d[1:0] !== 2'b10) $display("FAIL done_race: got %b, required 10", d[1:0]);
    else passed++;
    wb_write(3'd0, 32'h2);
    wb_read(3'd0, d);
    total++;
    if (d[1:0] !== 2'b00) $display("FAIL done_w1c: got %b, required 00", d[1:0]);
    else passed++;
    last_rx = tx;
  endtask

`ifdef WB_SPI_MULTI_IRQ_EN
  task automatic test_irq;
    int unsigned t0;
    loopback = 1'b1;
    wb_write(3'd0, 32'h46);
    wb_write(3'd2, 32'd0);
    wb_write(3'd3, 32'd0);
    total++;
    if (irq !== 1'b0) $display("FAIL irq_idle: got %b, required 0", irq);
    else passed++;
    wb_write(3'd1, $urandom);
    t0 = ack_cyc;
    while (spi_cs_n !== 4'b1111 && cyc_cnt < t0 + 100) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (irq !== 1'b1) $display("FAIL irq_set: got %b, required 1", irq);
    else passed++;
    wb_write(3'd0, 32'h42);
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b0) $display("FAIL irq_clear: got %b, required 0", irq);
    else passed++;
  endtask
`endif

  task automatic test_reset_mid;
    logic [31:0] d;
    loopback = 1'b1;
    wb_write(3'd0, 32'hE);
    wb_write(3'd2, 32'd0);
    wb_write(3'd3, 32'd3);
    wb_write(3'd1, 32'hFF);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({spi_cs_n, spi_sck, spi_mosi, wb_dat_o} !== {{NCS{1'b1}}, 2'b00, 32'd0})
      $display("FAIL reset_mid_pins: got cs_n=%b sck=%b mosi=%b dat=%h, required 1111 0 0 0",
               spi_cs_n, spi_sck, spi_mosi, wb_dat_o);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    repeat (60) @(posedge clk);
    wb_read(3'd0, d);
    total++;
    if (d !== 32'd0) $display("FAIL reset_mid_ctrl: got %h, required 0", d);
    else passed++;
    wb_read(3'd1, d);
    total++;
    if (d !== 32'd0) $display("FAIL reset_mid_rx: got %h, required 0", d);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_mode3_lsb();
    test_random();
    test_overrun();
    test_div_busy();
    test_done_race();
`ifdef WB_SPI_MULTI_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
